// File: rtl/ex_div_if.sv
// Handshake between the EX stage and the iterative divider: the operand request
// going in, and the stall, busy and result signals coming back.
interface ex_div_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        stallreq_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        busy_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    input  stallreq_o, result_valid_o, result_o, busy_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    output stallreq_o, result_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ex_div_unit.sv
// Restoring 32-bit divider for div.w/mod.w/div.wu/mod.wu. Takes 34 cycles in EX,
// stalls ID/EX while it works, and is cancelled by any of the three flushes.
//   state  | meaning
//   IDLE   | waiting for a divide op at the EX inputs
//   CALC   | 32 iterations, one quotient bit per cycle, MSB first
//   DONE   | one-cycle result pulse toward the EX result mux
module ex_div_unit (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     excp_flush,
  input  logic     ertn_flush,
  ex_div_if.slave  div_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mod_q, mod_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] raw_q, raw_d;
  logic [31:0] res_q, res_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        kill;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] final_res;

  always_comb begin
    kill      = flush | excp_flush | ertn_flush;
    is_signed = ~div_if.op_i[1];
    a_neg     = is_signed & div_if.dividend_i[31];
    b_neg     = is_signed & div_if.divisor_i[31];
    a_mag     = a_neg ? (~div_if.dividend_i + 32'd1) : div_if.dividend_i;
    b_mag     = b_neg ? (~div_if.divisor_i + 32'd1) : div_if.divisor_i;

    // quo_q doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    shifted = {rem_q[31:0], quo_q[31]};
    ge      = rem_q[32] | (shifted >= {1'b0, dvs_q});

    if (dz_q)
      final_res = mod_q ? raw_q : 32'hFFFF_FFFF;
    else if (mod_q)
      final_res = r_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    else
      final_res = q_neg_q ? (~quo_q + 32'd1) : quo_q;
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    res_d   = res_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (div_if.start_i && !kill) begin
          mod_d   = div_if.op_i[0];
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (div_if.divisor_i == 32'd0);
          quo_d   = a_mag;
          dvs_d   = b_mag;
          raw_d   = div_if.dividend_i;
          rem_d   = 33'd0;
          cnt_d   = 5'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (ge) begin
          rem_d = shifted - {1'b0, dvs_q};
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (!kill)
          res_d = final_res;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mod_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      raw_q   <= 32'd0;
      res_q   <= 32'd0;
      rem_q   <= 33'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    div_if.stallreq_o     = (((state_q == S_IDLE) & div_if.start_i) | (state_q == S_CALC)) & ~kill;
    div_if.result_valid_o = (state_q == S_DONE) & ~kill;
    div_if.result_o       = (state_q == S_DONE) ? final_res : res_q;
    div_if.busy_o         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: each issued op pushes its expected result and
// accept cycle into a scoreboard; a monitor pops on every result pulse.
module tb_ex_div_unit;

  logic clk;
  logic rst;
  logic flush;
  logic excp_flush;
  logic ertn_flush;

  ex_div_if bus ();

  ex_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .excp_flush (excp_flush),
    .ertn_flush (ertn_flush),
    .div_if     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          t_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #1;
    if (!rst && bus.result_valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: result_valid_o=1 with result %08h at cycle %0d, none expected",
                 bus.result_o, cyc);
      end else begin
        logic [31:0] e;
        int t;
        e = exp_q.pop_front();
        t = t_q.pop_front();
        if (bus.result_o !== e) begin
          n_fail++;
          $display("FAIL result: got %08h expected %08h (accept cycle %0d)", bus.result_o, e, t);
        end
        n_checks++;
        if (cyc - t != 33) begin
          n_fail++;
          $display("FAIL latency: got %0d expected 33", cyc - t);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Called at a negedge with the divider idle; returns at the negedge after the pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit chk_stall);
    int  scnt;
    bit  got;
    scnt = 0;
    got  = 0;
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    exp_q.push_back(exp);
    t_q.push_back(cyc);
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.stallreq_o) scnt++;
      if (i == 0) check("busy_at_accept", {31'd0, bus.busy_o}, 32'd0);
      if (i == 1) check("busy_in_calc", {31'd0, bus.busy_o}, 32'd1);
      if (bus.result_valid_o) begin
        got = 1;
        check("stall_in_done", {31'd0, bus.stallreq_o}, 32'd0);
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      if (got) break;
    end
    if (!got) begin
      bus.start_i = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no result pulse for op %0d %08h/%08h", op, a, b);
    end
    if (chk_stall) check("stall_cycles", scnt, 32'd33);
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    #1;
    check("rst_stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    check("rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b01, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1'b0);
    run_op(2'b01, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    check("result_held", bus.result_o, 32'd1);

    // Exception flush mid-divide: no pulse for the cancelled op.
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b00;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd7;
    repeat (10) @(negedge clk);
    excp_flush = 1'b1;
    #1;
    check("flush_stall_drop", {31'd0, bus.stallreq_o}, 32'd0);
    check("flush_busy", {31'd0, bus.busy_o}, 32'd1);
    @(negedge clk);
    excp_flush = 1'b0;
    run_op(2'b00, 32'd9, 32'd3, 32'd3, 1'b0);

    // Kill together with start in IDLE must not accept.
    bus.start_i = 1'b1;
    flush       = 1'b1;
    #1;
    check("kill_start_stall", {31'd0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    flush       = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("kill_start_idle", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-CALC.
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b00;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    check("arst_valid", {31'd0, bus.result_valid_o}, 32'd0);
    check("arst_result", bus.result_o, 32'd0);
    check("arst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("arst_state", {30'd0, dut.state_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'b11, 32'd10, 32'd3, 32'd1, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit integer divider in the EX stage. It takes the operands and ALU op that the ID/EX pipeline register presents to EX and computes LoongArch `div.w`, `mod.w`, `div.wu` and `mod.wu` over 34 cycles. While busy it drives `stallreq_o` back toward ID/EX so the instruction stays parked at the EX inputs. It returns the result to the EX result mux on a one-cycle valid pulse.

## Interface
Parameters:
- none (width fixed at 32; iteration count fixed at 32)

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: branch flush; cancels any operation.
- `excp_flush` in 1: exception flush; cancels any operation.
- `ertn_flush` in 1: ertn flush; cancels any operation.
- `start_i` in 1: the EX instruction is valid and is a divide/modulo op.
- `op_i` in 2: 00 `div.w`, 01 `mod.w`, 10 `div.wu`, 11 `mod.wu`.
- `dividend_i` in 32: rj operand (ex_reg1).
- `divisor_i` in 32: rk operand (ex_reg2).
- `stallreq_o` out 1: hold ID/EX and everything upstream.
- `result_valid_o` out 1: one-cycle pulse; `result_o` is final.
- `result_o` out 32: quotient or remainder.
- `busy_o` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- "Kill" means any of `flush`, `excp_flush` or `ertn_flush` is 1.
- IDLE:
  - Condition: `start_i` = 1 and no kill → accept.
  - Latch `op_i`.
  - Signed ops: latch the magnitudes `|dividend_i|` and `|divisor_i|`, then:
    - quotient sign = dividend sign XOR divisor sign;
    - remainder sign = dividend sign.
  - Unsigned ops: latch raw values; both signs = 0.
  - Latch a zero-divisor flag and the raw dividend.
  - Clear the 33-bit partial remainder; count := 0; next state CALC.
- CALC (restoring, one quotient bit per cycle, MSB first):
  - Shift the partial remainder left, bringing in the next dividend bit.
  - If partial remainder ≥ divisor magnitude: subtract, quotient bit = 1; else quotient bit = 0.
  - count increments each cycle. Leave for DONE after the cycle with count = 31, i.e. 32 iterations.
- DONE:
  - `result_valid_o` = 1.
  - `result_o` = signed-corrected quotient (ops 00/10) or remainder (01/11).
  - Next state IDLE unconditionally. DONE never accepts a start, so the held instruction cannot re-trigger.
- Zero divisor, any op: quotient = 0xFFFFFFFF, remainder = raw `dividend_i`. This overrides sign correction and keeps the same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of magnitude arithmetic; no special case is needed.
- `stallreq_o` = ((IDLE & `start_i`) | CALC) & ~kill. It is combinational and low in DONE.
- `result_o` is combinational from the final registers; it is valid only while `result_valid_o` = 1. It holds its value otherwise (0 after reset).
- Kill in any state → IDLE on the next edge:
  - no `result_valid_o` pulse;
  - `stallreq_o` drops in the kill cycle itself;
  - in DONE, the kill forces `result_valid_o` to 0 that cycle.
- Reset (any time, including mid-CALC) → IDLE immediately. All outputs go to 0.

## Timing
- Accept at cycle T (IDLE, `start_i`=1). CALC occupies T+1..T+32. DONE is at T+33.
- `stallreq_o` is high T..T+32 and low at T+33, so ID/EX advances at the end of T+33.
- Total EX residency is 34 cycles. The earliest back-to-back accept is T+34.
- `busy_o` is high T+1..T+33.
- Operands are sampled only at T. Input changes during CALC/DONE are ignored.
- Reset values:
  - state IDLE, count 0, internal registers 0;
  - `stallreq_o` 0 unless `start_i` is high;
  - `result_valid_o` 0, `result_o` 0, `busy_o` 0.
- Kill in the same cycle as `start_i` in IDLE: no accept; state stays IDLE; `stallreq_o` 0.

## Test plan
- `div.w` 100 / 7, `start_i` held until the pulse:
  - `stallreq_o` is high for 33 cycles;
  - `result_valid_o` pulses exactly 33 cycles after accept, with `result_o` = 14.
- `mod.w` −7 (0xFFFFFFF9) mod 2 → 0xFFFFFFFF; `div.w` −7 / 2 → 0xFFFFFFFD; `div.wu` 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- `div.w` 0x80000000 / 0xFFFFFFFF → 0x80000000; `mod.w` of the same operands → 0.
- `div.wu` 5 / 0 → 0xFFFFFFFF, and `mod.w` 0xFFFFFFF0 mod 0 → 0xFFFFFFF0. Both at the T+33 latency.
- `excp_flush` pulsed at T+10 during a divide:
  - `stallreq_o` drops that cycle;
  - no `result_valid_o` pulse;
  - a new `div.w` 9 / 3 accepted at T+11 yields 3 at T+44.
- `rst` asserted asynchronously mid-CALC:
  - all outputs are 0 and the state is IDLE before the next edge;
  - after release, a fresh `mod.wu` 10 mod 3 returns 1.
